fifo_out_ctrl: RTL
==================

FIFO_OUT_CTRL -- requirements
Module: fifo_out_ctrl

Interface
REQ-001 Parameter: DW, 32, data width of requester and FIFO data.
REQ-002 Parameter: DEPTH, 32, FIFO capacity in words; the occupancy counter is 6 bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req0 / req1  in  1 each  write request from producer 0 / 1; held high until the matching ack.
REQ-006 din0 / din1  in  DW each  write data; held stable while the matching req is high.
REQ-007 ack0 / ack1  out  1 each  one-cycle pulse; the word was written this cycle.
REQ-008 rd_req  in  1  consumer read request, level-sensitive.
REQ-009 rd_ack  out  1  one-cycle pulse; a read was issued this cycle.
REQ-010 rd_valid  out  1  high the cycle after rd_ack; FIFO output data is valid.
REQ-011 fifo_wr_en / fifo_rd_en  out  1 each  FIFO port strobes; never both high in the same cycle.
REQ-012 fifo_din  out  DW  data of the granted producer.
REQ-013 fifo_state  in  3  FIFO state: IDLE 000, WRITE 001, READ 010, WR_ERROR 011, RD_ERROR 100.
REQ-014 occ  out  6  internal occupancy count, range 0..DEPTH.
REQ-015 err  out  1  sticky error flag.

Function
REQ-016 Outputs shall be registered; a grant decided from inputs in cycle N appears on strobes, acks and fifo_din in cycle N+1.
REQ-017 Write candidate: (req0 and not ack0) or (req1 and not ack1), and occ < DEPTH.
REQ-018 Read candidate: rd_req and occ > 0.
REQ-019 At most one operation shall be issued per cycle: a single fifo_wr_en or a single fifo_rd_en.
REQ-020 Read/write tie: when both are candidates, the controller shall issue the opposite of the last operation issued; after reset, write goes first.
REQ-021 Producer tie: when both producers are eligible, grant round-robin; the pointer moves past a producer only when that producer is granted; producer 0 goes first after reset.
REQ-022 A producer whose ack is high this cycle shall not be granted this cycle, so there are at least 2 cycles between grants to the same producer.
REQ-023 ackX shall be asserted in the same cycle as the fifo_wr_en that carries dinX.
REQ-024 Reads may be back-to-back; rd_ack coincides with fifo_rd_en, and rd_valid equals fifo_rd_en delayed by 1 cycle.
REQ-025 occ shall increment on each issued write and decrement on each issued read; it never wraps.
REQ-026 Full (occ = DEPTH): writes are blocked and producers are held; reads continue.
REQ-027 Empty (occ = 0): reads are blocked; rd_req is held without rd_ack.
REQ-028 FSM states and encoding: C_IDLE 00 (no op issued), C_WRITE 01, C_READ 10.
REQ-029 FSM transitions: next state = C_WRITE if a write is issued, C_READ if a read is issued, else C_IDLE; the last-operation memory for REQ-020 is kept separately and is not cleared by C_IDLE.
REQ-030 err shall set when fifo_state is WR_ERROR or RD_ERROR; it clears only on reset; operation continues while err is set.

Reset
REQ-031 Asserting reset shall immediately clear ack0, ack1, rd_ack, rd_valid, fifo_wr_en, fifo_rd_en, fifo_din, occ and err, and set the FSM to C_IDLE, the RR pointer to 0 and the last operation to READ.
REQ-032 A reset asserted mid-operation shall abort the in-flight op with no ack; after release the controller operates normally from the first clock edge.

Structure
REQ-033 Package fifo_out_pkg shall hold the FIFO state encodings (000..100), the controller state encodings, and the DEPTH and DW defaults, shared with the FIFO.
REQ-034 Producer arbitration shall be a sub-module rr_arb2: a 2-way round-robin arbiter with req[1:0] and advance in, grant[1:0] out.

Verification
REQ-035 Single write: req0=1, din0=0xA5 in cycle 0 -> cycle 1 fifo_wr_en=1, fifo_din=0xA5, ack0=1; occ=1 after cycle 1.
REQ-036 Two producers, req0 and req1 held high -> grants alternate 0,1,0,1; no consecutive grants to the same producer; fifo_wr_en and fifo_rd_en never high together.
REQ-037 Fill to 32, then req0 held -> no ack0 while occ=32; one rd_req read -> occ=31, then ack0 within 2 cycles.
REQ-038 Empty with rd_req held -> no rd_ack; one write -> next cycle rd_ack=1, the following cycle rd_valid=1, occ returns to 0.
REQ-039 Concurrent req0 and rd_req with occ=5 -> strobes alternate WR,RD,WR,RD; occ oscillates 6,5,6,5.
REQ-040 Drive fifo_state=011 for 1 cycle -> err=1 and stays 1; assert reset mid-write -> all outputs 0, occ=0 immediately.

Source files
------------

// File: rtl/fifo_out_pkg.sv
// Shared encodings and defaults for the output-side FIFO controller and the FIFO itself.
package fifo_out_pkg;
    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 32;
    localparam int OCC_W     = 6;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'b000,
        FS_WRITE    = 3'b001,
        FS_READ     = 3'b010,
        FS_WR_ERROR = 3'b011,
        FS_RD_ERROR = 3'b100
    } fifo_state_e;

    typedef enum logic [1:0] {
        C_IDLE  = 2'b00,
        C_WRITE = 2'b01,
        C_READ  = 2'b10
    } ctrl_state_e;

    typedef enum logic {
        LAST_WRITE = 1'b0,
        LAST_READ  = 1'b1
    } last_op_e;

    function automatic logic is_fifo_error(input logic [2:0] st);
        return (st == FS_WR_ERROR) || (st == FS_RD_ERROR);
    endfunction
endpackage

// File: rtl/fifo_out_ctrl_if.sv
// Producer, consumer and FIFO-port signals of fifo_out_ctrl; master is the controller side.
interface fifo_out_ctrl_if #(
    parameter int DW = fifo_out_pkg::DEF_DW
);
    import fifo_out_pkg::*;

    logic                req0;
    logic                req1;
    logic [DW-1:0]       din0;
    logic [DW-1:0]       din1;
    logic                ack0;
    logic                ack1;
    logic                rd_req;
    logic                rd_ack;
    logic                rd_valid;
    logic                fifo_wr_en;
    logic                fifo_rd_en;
    logic [DW-1:0]       fifo_din;
    logic [2:0]          fifo_state;
    logic [OCC_W-1:0]    occ;
    logic                err;

    modport master (
        input  req0, req1, din0, din1, rd_req, fifo_state,
        output ack0, ack1, rd_ack, rd_valid, fifo_wr_en, fifo_rd_en, fifo_din, occ, err
    );

    modport slave (
        output req0, req1, din0, din1, rd_req, fifo_state,
        input  ack0, ack1, rd_ack, rd_valid, fifo_wr_en, fifo_rd_en, fifo_din, occ, err
    );
endinterface

// File: rtl/fifo_out_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer only moves past a producer once it is granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        // Granting producer 0 hands priority to 1, granting 1 hands it back to 0.
        if (advance && (grant != 2'b00)) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/fifo_out_ctrl.sv
// Arbitrates two write producers and one reader onto a single-port FIFO, one operation per cycle.
module fifo_out_ctrl
    import fifo_out_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    fifo_out_ctrl_if.master bus
);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    ctrl_state_e      state_q, state_d;
    last_op_e         last_op_q, last_op_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             rd_valid_q, rd_valid_d;
    logic             err_q, err_d;
    logic [DW-1:0]    fifo_din_q, fifo_din_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [1:0] elig;
    logic [1:0] grant;
    logic       wr_cand;
    logic       rd_cand;
    logic       do_wr;
    logic       do_rd;

    // A producer being acked this cycle still has its old req high; it must not be re-granted.
    assign elig    = {bus.req1 & ~ack1_q, bus.req0 & ~ack0_q};
    assign wr_cand = (|elig) && (occ_q < OCC_FULL);
    assign rd_cand = bus.rd_req && (occ_q != '0);
    assign do_wr   = wr_cand && (!rd_cand || (last_op_q == LAST_READ));
    assign do_rd   = rd_cand && !do_wr;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (elig),
        .advance (do_wr),
        .grant   (grant)
    );

    always_comb begin
        state_d    = C_IDLE;
        last_op_d  = last_op_q;
        fifo_din_d = fifo_din_q;
        occ_d      = occ_q;
        if (do_wr) begin
            state_d    = C_WRITE;
            last_op_d  = LAST_WRITE;
            fifo_din_d = grant[1] ? bus.din1 : bus.din0;
            occ_d      = occ_q + 1'b1;
        end else if (do_rd) begin
            state_d    = C_READ;
            last_op_d  = LAST_READ;
            occ_d      = occ_q - 1'b1;
        end
        ack0_d     = do_wr & grant[0];
        ack1_d     = do_wr & grant[1];
        rd_valid_d = (state_q == C_READ);
        err_d      = err_q | is_fifo_error(bus.fifo_state);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= C_IDLE;
            last_op_q  <= LAST_READ;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            fifo_din_q <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_op_q  <= last_op_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            fifo_din_q <= fifo_din_d;
            occ_q      <= occ_d;
        end
    end

    // Strobes decode straight from the state register, so write and read can never overlap.
    assign bus.fifo_wr_en = (state_q == C_WRITE);
    assign bus.fifo_rd_en = (state_q == C_READ);
    assign bus.rd_ack     = (state_q == C_READ);
    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.fifo_din   = fifo_din_q;
    assign bus.occ        = occ_q;
    assign bus.err        = err_q;
endmodule
